// File: rtl/aes_pkg.sv
// Shared AES-128 primitives for the iterative encryptor and decryptor.
// Byte ordering is FIPS-197 column-major: bits [127:120] hold byte 0.
package aes_pkg;

   localparam int NK_WORDS  = 4;
   localparam int NR_ROUNDS = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

   // Ascending range so element 0 lands on the most significant byte.
   typedef logic [0:15][7:0] block_t;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   // Entry b sits at bit offset (255-b)*8 because the table lists entry 0 first.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic block_t shift_rows(input block_t s);
      block_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[4*c+r] = s[4*((c+r)%4)+r];
      return o;
   endfunction

   function automatic block_t inv_shift_rows(input block_t s);
      block_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[4*c+r] = s[4*((c+4-r)%4)+r];
      return o;
   endfunction

   function automatic block_t mix_columns(input block_t s);
      block_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[4*c];
         a1 = s[4*c+1];
         a2 = s[4*c+2];
         a3 = s[4*c+3];
         o[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic block_t inv_mix_columns(input block_t s);
      block_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[4*c];
         a1 = s[4*c+1];
         a2 = s[4*c+2];
         a3 = s[4*c+3];
         o[4*c]   = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
         o[4*c+1] = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
         o[4*c+2] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
         o[4*c+3] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
      end
      return o;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3;
      w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rcon, 24'h000000};
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_encrypt_core_if.sv
// Plaintext/key input handshake and ciphertext output handshake of the encryptor.
interface aes_encrypt_core_if;
   import aes_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [127:0]            data_in;
   logic [NK_WORDS*32-1:0]  key_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [127:0]            data_out;
   logic                    busy;

   modport master (
      output in_valid, data_in, key_in, out_ready,
      input  in_ready, out_valid, data_out, busy
   );

   modport slave (
      input  in_valid, data_in, key_in, out_ready,
      output in_ready, out_valid, data_out, busy
   );

endinterface

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round; MixColumns is skipped for the last round.
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         is_final,
   output logic [127:0] state_out
);

   block_t st;
   block_t sb;
   block_t sr;
   block_t mc;

   assign st = state_in;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub_bytes
         assign sb[gi] = sbox(st[gi]);
      end
   endgenerate

   assign sr        = shift_rows(sb);
   assign mc        = mix_columns(sr);
   assign state_out = (is_final ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor: one round per clock, round keys derived on the fly.
module aes_encrypt_core
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   aes_encrypt_core_if.slave bus
);

   generate
      if (Nk != NK_WORDS || Nr != NR_ROUNDS) begin : g_param_check
         $error("aes_encrypt_core supports only Nk=4, Nr=10");
      end
   endgenerate

   fsm_e         fsm_q, fsm_d;
   block_t       state_q, state_d;
   logic [127:0] rk_q, rk_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] data_out_q, data_out_d;
   logic         out_valid_q, out_valid_d;

   logic [127:0] next_rk;
   logic [127:0] round_out;

   assign next_rk = key_step(rk_q, rcon_q);

   aes_enc_round u_round (
      .state_in  (state_q),
      .round_key (next_rk),
      .is_final  (fsm_q == FINAL),
      .state_out (round_out)
   );

   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      rk_d        = rk_q;
      rcon_d      = rcon_q;
      round_d     = round_q;
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q;
      case (fsm_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = bus.data_in ^ bus.key_in;
               rk_d    = bus.key_in;
               rcon_d  = RCON_INIT;
               round_d = 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            state_d = round_out;
            rk_d    = next_rk;
            rcon_d  = xtime(rcon_q);
            round_d = round_q + 4'd1;
            if (round_q == 4'd9) fsm_d = FINAL;
         end
         FINAL: begin
            data_out_d  = round_out;
            out_valid_d = 1'b1;
            fsm_d       = DONE;
         end
         DONE: begin
            // Ciphertext is held until the consumer takes it; no early release.
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         rk_q        <= '0;
         rcon_q      <= '0;
         round_q     <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         rk_q        <= rk_d;
         rcon_q      <= rcon_d;
         round_q     <= round_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = rst_n && (fsm_q == IDLE);
   assign bus.busy      = (fsm_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.data_out  = data_out_q;

endmodule
